// File: rtl/shiftreg_pkg.sv
// rtl/shiftreg_pkg.sv - shared state encoding and line level for the serial transfer engine
package shiftreg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic SER_IDLE = 1'b1;

endpackage

// File: rtl/shiftreg_core.sv
// rtl/shiftreg_core.sv - parametrised load/shift register with serial in-bit and out-bit
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load_i       parallel load of load_data_i (has priority over shift_i)
//   load_data_i  word to load
//   shift_i      shift one place toward the out end, in_bit_i enters at the vacated end
//   in_bit_i     serial bit entering the register
//   data_o       current register contents
//   out_bit_o    bit at the out end (MSB when LSB_FIRST = 0, LSB when LSB_FIRST = 1)
module shiftreg_core #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_i,
    input  logic             in_bit_i,
    output logic [WIDTH-1:0] data_o,
    output logic             out_bit_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_shifted;

    generate
        if (LSB_FIRST) begin : g_lsb
            assign sr_shifted = {in_bit_i, sr_q[WIDTH-1:1]};
            assign out_bit_o  = sr_q[0];
        end else begin : g_msb
            assign sr_shifted = {sr_q[WIDTH-2:0], in_bit_i};
            assign out_bit_o  = sr_q[WIDTH-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= load_data_i;
        end else if (shift_i) begin
            sr_q <= sr_shifted;
        end
    end

    assign data_o = sr_q;

endmodule

// File: rtl/shiftreg_xfer.sv
// rtl/shiftreg_xfer.sv - strobe-timed serial transfer engine, optional odd parity (SHIFTREG_XFER_PARITY_EN)
//
// Loads a WIDTH-bit word via tx_valid/tx_ready, drives it on ser_o one bit per drv_en and
// captures ser_i one bit per smp_en. The received word appears on rx_data with a one-cycle
// rx_valid. Define SHIFTREG_XFER_PARITY_EN to append an odd-parity bit and report rx_perr.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   drv_en, smp_en      drive / sample strobes, synchronous to clk
//   tx_data, tx_valid   word to send and its valid
//   tx_ready            engine idle; word accepted on tx_valid & tx_ready
//   ser_i, ser_o        serial input, registered serial output (idle high)
//   rx_data, rx_valid   received word (held) and its one-cycle valid
//   rx_perr             parity error for rx_data (always 0 without parity)
//   busy                transfer in progress
module shiftreg_xfer
    import shiftreg_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             drv_en,
    input  logic             smp_en,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             ser_i,
    output logic             ser_o,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             rx_perr,
    output logic             busy
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ser_q, ser_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_perr_q, rx_perr_d;

    logic             sr_load;
    logic             sr_shift;
    logic [WIDTH-1:0] sr_data;
    logic             sr_out;

`ifdef SHIFTREG_XFER_PARITY_EN
    logic tx_par_q, tx_par_d;
    logic par_rx_q, par_rx_d;
`endif

    shiftreg_core #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (sr_load),
        .load_data_i (tx_data),
        .shift_i     (sr_shift),
        .in_bit_i    (ser_i),
        .data_o      (sr_data),
        .out_bit_o   (sr_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ser_q      <= SER_IDLE;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
`ifdef SHIFTREG_XFER_PARITY_EN
            tx_par_q   <= 1'b0;
            par_rx_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ser_q      <= ser_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_perr_q  <= rx_perr_d;
`ifdef SHIFTREG_XFER_PARITY_EN
            tx_par_q   <= tx_par_d;
            par_rx_q   <= par_rx_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ser_d      = ser_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_perr_d  = rx_perr_q;
        sr_load    = 1'b0;
        sr_shift   = 1'b0;
`ifdef SHIFTREG_XFER_PARITY_EN
        tx_par_d   = tx_par_q;
        par_rx_d   = par_rx_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    sr_load = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
`ifdef SHIFTREG_XFER_PARITY_EN
                    tx_par_d = ~^tx_data;
`endif
                end
            end
            ST_SHIFT: begin
                // ser_d takes the pre-shift out bit, so a coincident smp_en acts drive-first
                if (drv_en) begin
                    ser_d = sr_out;
                end
                if (smp_en) begin
                    sr_shift = 1'b1;
                    // The count saturates at WIDTH-1: that strobe is the last data bit
                    if (cnt_q == CNT_LAST) begin
`ifdef SHIFTREG_XFER_PARITY_EN
                        state_d = ST_PAR;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
`ifdef SHIFTREG_XFER_PARITY_EN
            ST_PAR: begin
                if (drv_en) begin
                    ser_d = tx_par_q;
                end
                if (smp_en) begin
                    par_rx_d = ser_i;
                    state_d  = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                // rx_valid is registered alongside rx_data so both change in the same cycle
                rx_data_d  = sr_data;
                rx_valid_d = 1'b1;
`ifdef SHIFTREG_XFER_PARITY_EN
                rx_perr_d  = (par_rx_q != ~^sr_data);
`else
                rx_perr_d  = 1'b0;
`endif
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tx_ready = (state_q == ST_IDLE);
    assign busy     = ~tx_ready;
    assign ser_o    = ser_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_perr  = rx_perr_q;

endmodule

// File: tb/tb_shiftreg_xfer.sv
// tb/tb_shiftreg_xfer.sv - directed self-checking bench for shiftreg_xfer
module tb_shiftreg_xfer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       drv_en, smp_en;
    logic [7:0] tx_data;
    logic       tx_valid_m, tx_valid_l;
    logic       loop_m, force_m;
    logic       ser_i_m, ser_i_l;

    logic       tx_ready_m, ser_o_m, rx_valid_m, rx_perr_m, busy_m;
    logic [7:0] rx_data_m;
    logic       tx_ready_l, ser_o_l, rx_valid_l, rx_perr_l, busy_l;
    logic [7:0] rx_data_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ser_i_m = loop_m ? ser_o_m : force_m;

    shiftreg_xfer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .drv_en   (drv_en),
        .smp_en   (smp_en),
        .tx_data  (tx_data),
        .tx_valid (tx_valid_m),
        .tx_ready (tx_ready_m),
        .ser_i    (ser_i_m),
        .ser_o    (ser_o_m),
        .rx_data  (rx_data_m),
        .rx_valid (rx_valid_m),
        .rx_perr  (rx_perr_m),
        .busy     (busy_m)
    );

    shiftreg_xfer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
        .clk      (clk),
        .rst_n    (rst_n),
        .drv_en   (drv_en),
        .smp_en   (smp_en),
        .tx_data  (tx_data),
        .tx_valid (tx_valid_l),
        .tx_ready (tx_ready_l),
        .ser_i    (ser_i_l),
        .ser_o    (ser_o_l),
        .rx_data  (rx_data_l),
        .rx_valid (rx_valid_l),
        .rx_perr  (rx_perr_l),
        .busy     (busy_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // MSB-first transfer, one drv_en then one smp_en per bit; bits collects ser_o, first bit highest
    task automatic xfer_m(input logic [7:0] d, input int nb, input bit inv_last, output logic [8:0] bits);
        tx_data    = d;
        tx_valid_m = 1'b1;
        step();
        tx_valid_m = 1'b0;
        bits = '0;
        for (int k = 0; k < nb; k++) begin
            drv_en = 1'b1;
            step();
            drv_en = 1'b0;
            bits = {bits[7:0], ser_o_m};
            if (inv_last && k == nb - 1) begin
                force_m = ~ser_o_m;
                loop_m  = 1'b0;
            end
            smp_en = 1'b1;
            step();
            smp_en = 1'b0;
            loop_m = 1'b1;
        end
    endtask

    task automatic wait_rx_m(output int n, output logic [7:0] rd);
        n  = 0;
        rd = 8'h00;
        for (int i = 0; i < 6; i++) begin
            if (rx_valid_m) begin
                n++;
                rd = rx_data_m;
            end
            step();
        end
    endtask

    initial begin
        logic [8:0] bits;
        int         n;
        logic [7:0] rd;

        rst_n = 1'b0; drv_en = 1'b0; smp_en = 1'b0; tx_data = 8'h00;
        tx_valid_m = 1'b0; tx_valid_l = 1'b0; loop_m = 1'b1; force_m = 1'b0; ser_i_l = 1'b0;
        step(); step();
        check("rst_ser_o", ser_o_m, 1);
        check("rst_tx_ready", tx_ready_m, 1);
        check("rst_rx_valid", rx_valid_m, 0);
        check("rst_rx_data", rx_data_m, 8'h00);
        check("rst_busy", busy_m, 0);
        rst_n = 1'b1;
        step();

        // strobes in IDLE must not start anything
        drv_en = 1'b1; smp_en = 1'b1; step(); step();
        drv_en = 1'b0; smp_en = 1'b0;
        check("idle_strobe_ready", tx_ready_m, 1);

`ifndef SHIFTREG_XFER_PARITY_EN
        // MSB-first loopback of A5
        xfer_m(8'hA5, 8, 1'b0, bits);
        check("a5_ser_bits", bits[7:0], 8'hA5);
        check("a5_done_busy", busy_m, 1);
        wait_rx_m(n, rd);
        check("a5_rx_pulses", n, 1);
        check("a5_rx_data", rd, 8'hA5);
        check("a5_rx_perr", rx_perr_m, 0);
        check("a5_ready_after", tx_ready_m, 1);

        // reset mid-transfer: bits 1 then 0 driven, so ser_o = 0 before reset
        tx_data = 8'hA5; tx_valid_m = 1'b1; step(); tx_valid_m = 1'b0;
        drv_en = 1'b1; step(); drv_en = 1'b0;
        smp_en = 1'b1; step(); smp_en = 1'b0;
        drv_en = 1'b1; step(); drv_en = 1'b0;
        check("pre_rst_ser_o", ser_o_m, 0);
        check("pre_rst_busy", busy_m, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ser_o", ser_o_m, 1);
        check("mid_rst_tx_ready", tx_ready_m, 1);
        check("mid_rst_rx_valid", rx_valid_m, 0);
        check("mid_rst_rx_data", rx_data_m, 8'h00);
        step();
        rst_n = 1'b1;
        wait_rx_m(n, rd);
        check("post_rst_no_rx", n, 0);

        // LSB-first 01 with ser_i held high
        tx_data = 8'h01; tx_valid_l = 1'b1; step(); tx_valid_l = 1'b0;
        ser_i_l = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drv_en = 1'b1; step(); drv_en = 1'b0;
            check($sformatf("lsb_bit%0d", k), ser_o_l, (k == 0) ? 1 : 0);
            smp_en = 1'b1; step(); smp_en = 1'b0;
        end
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (rx_valid_l) begin
                n++;
                rd = rx_data_l;
            end
            step();
        end
        check("lsb_rx_pulses", n, 1);
        check("lsb_rx_data", rd, 8'hFF);
        ser_i_l = 1'b0;

        // simultaneous strobes every cycle; ser_i echoes the bit being driven
        tx_data = 8'h96; tx_valid_m = 1'b1; step(); tx_valid_m = 1'b0;
        loop_m = 1'b0;
        for (int k = 0; k < 8; k++) begin
            force_m = tx_data[7-k];
            drv_en = 1'b1; smp_en = 1'b1;
            step();
            check($sformatf("both_bit%0d", k), ser_o_m, tx_data[7-k]);
            if (k == 6) check("both_busy_7", busy_m, 1);
        end
        drv_en = 1'b0; smp_en = 1'b0;
        check("both_done_ready", tx_ready_m, 0);
        wait_rx_m(n, rd);
        check("both_rx_pulses", n, 1);
        check("both_rx_data", rd, 8'h96);
        loop_m = 1'b1;

        // tx_valid pulse with 3C while C3 is in flight
        tx_data = 8'hC3; tx_valid_m = 1'b1; step(); tx_valid_m = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                tx_data = 8'h3C; tx_valid_m = 1'b1;
            end
            drv_en = 1'b1; step(); drv_en = 1'b0;
            tx_valid_m = 1'b0;
            if (k == 2) check("busy_ready_low", tx_ready_m, 0);
            smp_en = 1'b1; step(); smp_en = 1'b0;
        end
        check("busy_done_ready", tx_ready_m, 0);
        wait_rx_m(n, rd);
        check("busy_rx_pulses", n, 1);
        check("busy_rx_data", rd, 8'hC3);
        drv_en = 1'b1; smp_en = 1'b1; step(); step(); step();
        drv_en = 1'b0; smp_en = 1'b0;
        check("busy_no_second", busy_m, 0);
        check("busy_ser_hold", ser_o_m, 1);
`else
        // odd parity of 07 (three ones) is 0
        xfer_m(8'h07, 9, 1'b0, bits);
        check("par_data_bits", bits[8:1], 8'h07);
        check("par_bit", bits[0], 0);
        wait_rx_m(n, rd);
        check("par_rx_pulses", n, 1);
        check("par_rx_data", rd, 8'h07);
        check("par_perr_ok", rx_perr_m, 0);
        xfer_m(8'h07, 9, 1'b1, bits);
        wait_rx_m(n, rd);
        check("par_bad_pulses", n, 1);
        check("par_bad_data", rd, 8'h07);
        check("par_perr_bad", rx_perr_m, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
